// File: rtl/led_strip_if.sv
// led_strip_if -- frame-request and serial-output bundle for led_strip_driver.
//
// Signals:
//   rgb        per-bin colour {R,G,B}, bin 0 in rgb[0]
//   LEDCounts  per-bin number of LEDs to paint with that bin's colour
//   brightness APA102 global brightness (unused for WS2801)
//   start      frame request, honoured only while done is high
//   done       driver idle and ready for a new frame
//   dOut       serial data to the strip
//   clkOut     serial clock to the strip
// Modports: master = frame requester, slave = driver.
interface led_strip_if #(
    parameter int BIN_QTY = 12,
    parameter int CNT_W   = 6
);
    logic [BIN_QTY-1:0][23:0]      rgb;
    logic [BIN_QTY-1:0][CNT_W-1:0] LEDCounts;
    logic [4:0]                    brightness;
    logic                          start;
    logic                          done;
    logic                          dOut;
    logic                          clkOut;

    modport master (
        output rgb, LEDCounts, brightness, start,
        input  done, dOut, clkOut
    );

    modport slave (
        input  rgb, LEDCounts, brightness, start,
        output done, dOut, clkOut
    );
endinterface

// File: rtl/led_strip_driver.sv
// led_strip_driver -- serialises a binned colour map onto a WS2801 or APA102
// LED strip.
//
// Ports:
//   clk  single clock, all logic on its rising edge
//   rst  asynchronous, active-low reset
//   bus  led_strip_if.slave: rgb / LEDCounts / brightness / start in,
//        done / dOut / clkOut out
//
// A frame is LEDS words, MSB first, each bit FREQ_DIV clks long with clkOut
// low for the first half. APA102 frames are wrapped in a 32-bit zero start
// frame and a max(32, ceil(LEDS/2))-bit all-ones end frame. Every frame ends
// with LATCH_CYC clks of clkOut=dOut=0 before done rises.
module led_strip_driver #(
    parameter int LEDS     = 50,
    parameter int BIN_QTY  = 12,
    parameter int FREQ     = 12_500_000,
    parameter int FREQ_DIV = 4,
    parameter int PROTOCOL = 0,
    parameter int LATCH_US = 500
) (
    input  logic       clk,
    input  logic       rst,
    led_strip_if.slave bus
);
    localparam int     CW          = $clog2(LEDS + 1);
    localparam int     BW          = (BIN_QTY > 1) ? $clog2(BIN_QTY) : 1;
    localparam int     DW          = $clog2(FREQ_DIV);
    localparam longint LATCH_CYC_L = longint'(FREQ) * longint'(LATCH_US) / 64'd1_000_000;
    localparam int     LATCH_CYC   = int'(LATCH_CYC_L);
    localparam int     LW          = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
    localparam int     EF_BITS     = (((LEDS + 1) / 2) > 32) ? ((LEDS + 1) / 2) : 32;
    localparam int     NW          = $clog2(EF_BITS + 1);
    localparam bit     APA         = (PROTOCOL == 1);
    localparam int     WORD_BITS   = APA ? 32 : 24;

    localparam logic [DW-1:0] DIV_LAST   = DW'(FREQ_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE    = DW'(FREQ_DIV - 2);
    localparam logic [DW-1:0] DIV_RISE   = DW'(FREQ_DIV / 2 - 1);
    localparam logic [LW-1:0] LATCH_LAST = LW'((LATCH_CYC > 0) ? LATCH_CYC - 1 : 0);
    localparam logic [CW-1:0] LEDS_C     = CW'(LEDS);

    typedef enum logic [2:0] {LATCH, IDLE, SFRAME, LOAD, SHIFT, EFRAME} state_t;

    state_t                   state_reg, state_next;
    logic [DW-1:0]            div_reg, div_next;       // clk phase within current bit
    logic [NW-1:0]            bits_reg, bits_next;     // bits still to start in segment
    logic [31:0]              sh_reg, sh_next;
    logic                     dout_reg, dout_next;
    logic                     clko_reg, clko_next;
    logic [LW-1:0]            latch_reg, latch_next;
    logic [CW-1:0]            led_reg, led_next;       // LED words loaded so far
    logic [BW-1:0]            bin_reg, bin_next;       // bin currently supplying colour
    logic [CW-1:0]            used_reg, used_next;     // LEDs taken from bin_reg
    logic [23:0]              last_reg, last_next;     // colour of last bin actually used
    logic [BIN_QTY-1:0][23:0] rgb_s_reg, rgb_s_next;
    logic [BIN_QTY-1:0][CW-1:0] cnt_s_reg, cnt_s_next;
    logic [4:0]               bri_reg, bri_next;

    // A bin can supply the next LED if it is the current bin with counts left,
    // or a later bin with a nonzero count. Searching all later bins in one
    // cycle is what lets zero-count bins vanish from the bit stream.
    logic [BIN_QTY-1:0] avail;
    genvar gi;
    generate
        for (gi = 0; gi < BIN_QTY; gi++) begin : g_avail
            localparam logic [BW-1:0] IDX = BW'(gi);
            assign avail[gi] = (IDX == bin_reg) ? (used_reg < cnt_s_reg[gi])
                                                : ((IDX > bin_reg) && (cnt_s_reg[gi] != '0));
        end
    endgenerate

    logic          found;
    logic [BW-1:0] sel;
    logic [23:0]   color;
    logic [31:0]   word;

    always_comb begin
        found = 1'b0;
        sel   = bin_reg;
        for (int j = BIN_QTY - 1; j >= 0; j--) begin
            if (avail[j]) begin
                found = 1'b1;
                sel   = BW'(j);
            end
        end
        // Once the counts run out the tail repeats the last colour used.
        color = found ? rgb_s_reg[sel] : last_reg;
        word  = APA ? {3'b111, bri_reg, color} : {color, 8'h00};
    end

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        bits_next  = bits_reg;
        sh_next    = sh_reg;
        dout_next  = dout_reg;
        clko_next  = clko_reg;
        latch_next = latch_reg;
        led_next   = led_reg;
        bin_next   = bin_reg;
        used_next  = used_reg;
        last_next  = last_reg;
        rgb_s_next = rgb_s_reg;
        cnt_s_next = cnt_s_reg;
        bri_next   = bri_reg;

        case (state_reg)
            LATCH: begin
                dout_next = 1'b0;
                clko_next = 1'b0;
                if (latch_reg >= LATCH_LAST) begin
                    state_next = IDLE;
                    latch_next = '0;
                end else begin
                    latch_next = latch_reg + LW'(1);
                end
            end
            IDLE: begin
                if (bus.start) begin
                    rgb_s_next = bus.rgb;
                    cnt_s_next = bus.LEDCounts;
                    bri_next   = bus.brightness;
                    led_next   = '0;
                    bin_next   = '0;
                    used_next  = '0;
                    last_next  = '0;
                    // Park the phase at the last slot so the next edge starts bit 0.
                    div_next   = DIV_LAST;
                    if (APA) begin
                        state_next = SFRAME;
                        bits_next  = NW'(32);
                        sh_next    = '0;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                // Occupies the final clk of the previous bit (or the lead-in clk
                // after IDLE); its edge launches the first bit of the new word.
                sh_next    = {word[30:0], 1'b0};
                dout_next  = word[31];
                bits_next  = NW'(WORD_BITS - 1);
                div_next   = '0;
                clko_next  = 1'b0;
                led_next   = led_reg + CW'(1);
                if (found) begin
                    bin_next  = sel;
                    used_next = (sel == bin_reg) ? used_reg + CW'(1) : CW'(1);
                    last_next = rgb_s_reg[sel];
                end
                state_next = SHIFT;
            end
            SFRAME, SHIFT, EFRAME: begin
                if (div_reg == DIV_LAST) begin
                    if (bits_reg != '0) begin
                        dout_next = sh_reg[31];
                        sh_next   = {sh_reg[30:0], (state_reg == EFRAME)};
                        bits_next = bits_reg - NW'(1);
                        div_next  = '0;
                        clko_next = 1'b0;
                    end else if (APA && state_reg == SHIFT) begin
                        state_next = EFRAME;
                        dout_next  = 1'b1;
                        sh_next    = '1;
                        bits_next  = NW'(EF_BITS - 1);
                        div_next   = '0;
                        clko_next  = 1'b0;
                    end else begin
                        state_next = LATCH;
                        dout_next  = 1'b0;
                        clko_next  = 1'b0;
                        latch_next = '0;
                        div_next   = '0;
                    end
                end else begin
                    div_next = div_reg + DW'(1);
                    if (div_reg == DIV_RISE) begin
                        clko_next = 1'b1;
                    end
                    // Prefetch the next LED word during the last clk of this bit.
                    if (div_reg == DIV_PRE && bits_reg == '0 &&
                        (state_reg == SFRAME || (state_reg == SHIFT && led_reg < LEDS_C))) begin
                        state_next = LOAD;
                    end
                end
            end
            default: state_next = LATCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= LATCH;
            div_reg   <= '0;
            bits_reg  <= '0;
            sh_reg    <= '0;
            dout_reg  <= 1'b0;
            clko_reg  <= 1'b0;
            latch_reg <= '0;
            led_reg   <= '0;
            bin_reg   <= '0;
            used_reg  <= '0;
            last_reg  <= '0;
            rgb_s_reg <= '0;
            cnt_s_reg <= '0;
            bri_reg   <= '0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            bits_reg  <= bits_next;
            sh_reg    <= sh_next;
            dout_reg  <= dout_next;
            clko_reg  <= clko_next;
            latch_reg <= latch_next;
            led_reg   <= led_next;
            bin_reg   <= bin_next;
            used_reg  <= used_next;
            last_reg  <= last_next;
            rgb_s_reg <= rgb_s_next;
            cnt_s_reg <= cnt_s_next;
            bri_reg   <= bri_next;
        end
    end

    assign bus.done   = (state_reg == IDLE);
    assign bus.dOut   = dout_reg;
    assign bus.clkOut = clko_reg;
endmodule

// File: tb/tb_led_strip_driver.sv
module tb_led_strip_driver;
    localparam int LEDS = 4;
    localparam int BINS = 4;
    localparam int CW   = 3;
    localparam int FREQ = 1_000_000;
    localparam int FDIV = 4;
    localparam int LUS  = 20;
    localparam int LCYC = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    led_strip_if #(.BIN_QTY(BINS), .CNT_W(CW)) if0 ();
    led_strip_if #(.BIN_QTY(BINS), .CNT_W(CW)) if1 ();

    led_strip_driver #(.LEDS(LEDS), .BIN_QTY(BINS), .FREQ(FREQ), .FREQ_DIV(FDIV),
                       .PROTOCOL(0), .LATCH_US(LUS)) u_ws (.clk(clk), .rst(rst), .bus(if0));
    led_strip_driver #(.LEDS(LEDS), .BIN_QTY(BINS), .FREQ(FREQ), .FREQ_DIV(FDIV),
                       .PROTOCOL(1), .LATCH_US(LUS)) u_apa (.clk(clk), .rst(rst), .bus(if1));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit q0[$];
    bit q1[$];
    int t0[$];
    int t1[$];
    int glitch0 = 0;
    int glitch1 = 0;
    logic pc0 = 1'b0, pc1 = 1'b0, pd0 = 1'b0, pd1 = 1'b0;

    // Capture a bit on each clkOut rise and flag dOut moving while clkOut is high.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (if0.clkOut === 1'b1 && pc0 === 1'b0) begin
            q0.push_back(if0.dOut);
            t0.push_back(cyc);
        end
        if (if1.clkOut === 1'b1 && pc1 === 1'b0) begin
            q1.push_back(if1.dOut);
            t1.push_back(cyc);
        end
        if (if0.dOut !== pd0 && if0.clkOut === 1'b1) glitch0 <= glitch0 + 1;
        if (if1.dOut !== pd1 && if1.clkOut === 1'b1) glitch1 <= glitch1 + 1;
        pc0 <= if0.clkOut;
        pc1 <= if1.clkOut;
        pd0 <= if0.dOut;
        pd1 <= if1.dOut;
    end

    function automatic logic [31:0] word_at(input bit p1, input int off, input int nb);
        logic [31:0] w;
        logic        b;
        w = '0;
        for (int i = 0; i < nb; i++) begin
            b = 1'bx;
            if (p1) begin
                if (off + i < q1.size()) b = q1[off + i];
            end else begin
                if (off + i < q0.size()) b = q0[off + i];
            end
            w = {w[30:0], b};
        end
        return w;
    endfunction

    // r/c are packed with bin 3 leftmost, bin 0 rightmost.
    task automatic set_bins(input bit p1, input logic [3:0][23:0] r,
                            input logic [3:0][2:0] c, input logic [4:0] br);
        if (p1) begin
            if1.rgb = r; if1.LEDCounts = c; if1.brightness = br;
        end else begin
            if0.rgb = r; if0.LEDCounts = c; if0.brightness = br;
        end
    endtask

    task automatic run_frame(input bit p1, output int cycles);
        if (p1) if1.start = 1'b1; else if0.start = 1'b1;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if0.start = 1'b0;
            if1.start = 1'b0;
        end while (((p1 ? if1.done : if0.done) !== 1'b1) && cycles < 3000);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (if0.done !== 1'b0)   begin bad++; $display("FAIL rst_done_ws got=%b want=0", if0.done); end
        total++; if (if0.dOut !== 1'b0)   begin bad++; $display("FAIL rst_dout_ws got=%b want=0", if0.dOut); end
        total++; if (if0.clkOut !== 1'b0) begin bad++; $display("FAIL rst_clk_ws got=%b want=0", if0.clkOut); end
        total++; if (if1.done !== 1'b0)   begin bad++; $display("FAIL rst_done_apa got=%b want=0", if1.done); end
        total++; if (if1.dOut !== 1'b0)   begin bad++; $display("FAIL rst_dout_apa got=%b want=0", if1.dOut); end
        total++; if (if1.clkOut !== 1'b0) begin bad++; $display("FAIL rst_clk_apa got=%b want=0", if1.clkOut); end
        rst = 1'b1;
        repeat (LCYC - 1) @(negedge clk);
        total++; if (if0.done !== 1'b0) begin bad++; $display("FAIL rst_early_ws got=%b want=0", if0.done); end
        total++; if (if1.done !== 1'b0) begin bad++; $display("FAIL rst_early_apa got=%b want=0", if1.done); end
        @(negedge clk);
        total++; if (if0.done !== 1'b1) begin bad++; $display("FAIL rst_ready_ws got=%b want=1", if0.done); end
        total++; if (if1.done !== 1'b1) begin bad++; $display("FAIL rst_ready_apa got=%b want=1", if1.done); end
        $display("reset: done rose after %0d clks", LCYC);
    endtask

    task automatic test_basic;
        logic [23:0] exp [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
        int base, g, n, gaps;
        logic [31:0] w;
        set_bins(0, {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000}, {3'd1, 3'd1, 3'd1, 3'd1}, 5'd0);
        base = q0.size(); g = glitch0;
        run_frame(0, n);
        total++; if (n !== 2 + 96 * FDIV + LCYC) begin bad++; $display("FAIL basic_cycles got=%0d want=%0d", n, 2 + 96 * FDIV + LCYC); end
        total++; if (q0.size() - base !== 96) begin bad++; $display("FAIL basic_nbits got=%0d want=96", q0.size() - base); end
        for (int k = 0; k < 4; k++) begin
            w = word_at(0, base + 24 * k, 24);
            total++; if (w[23:0] !== exp[k]) begin bad++; $display("FAIL basic_led%0d got=%06h want=%06h", k, w[23:0], exp[k]); end
        end
        gaps = 0;
        for (int i = base + 1; i < q0.size(); i++) if (t0[i] - t0[i - 1] != FDIV) gaps++;
        total++; if (gaps !== 0) begin bad++; $display("FAIL basic_spacing got=%0d irregular want=0", gaps); end
        total++; if (glitch0 - g !== 0) begin bad++; $display("FAIL basic_dout_high got=%0d changes want=0", glitch0 - g); end
        $display("basic ws2801 frame: %0d bits in %0d clks", q0.size() - base, n);
    endtask

    task automatic test_skip_zero;
        int base, n;
        logic [31:0] w;
        set_bins(0, {24'hDEAD00, 24'h00BEEF, 24'h123456, 24'h777777}, {3'd0, 3'd0, 3'd2, 3'd0}, 5'd0);
        base = q0.size();
        run_frame(0, n);
        total++; if (q0.size() - base !== 96) begin bad++; $display("FAIL skip_nbits got=%0d want=96", q0.size() - base); end
        for (int k = 0; k < 4; k++) begin
            w = word_at(0, base + 24 * k, 24);
            total++; if (w[23:0] !== 24'h123456) begin bad++; $display("FAIL skip_led%0d got=%06h want=123456", k, w[23:0]); end
        end
        $display("skip-zero ws2801 frame: %0d bits", q0.size() - base);
    endtask

    task automatic test_overflow;
        logic [23:0] exp [4] = '{24'hAAAAAA, 24'hAAAAAA, 24'hAAAAAA, 24'h555555};
        int base, n;
        logic [31:0] w;
        set_bins(0, {24'h111111, 24'h222222, 24'h555555, 24'hAAAAAA}, {3'd0, 3'd0, 3'd3, 3'd3}, 5'd0);
        base = q0.size();
        run_frame(0, n);
        total++; if (q0.size() - base !== 96) begin bad++; $display("FAIL over_nbits got=%0d want=96", q0.size() - base); end
        for (int k = 0; k < 4; k++) begin
            w = word_at(0, base + 24 * k, 24);
            total++; if (w[23:0] !== exp[k]) begin bad++; $display("FAIL over_led%0d got=%06h want=%06h", k, w[23:0], exp[k]); end
        end
        $display("overflow ws2801 frame: %0d bits", q0.size() - base);
    endtask

    task automatic test_all_zero;
        int base, n;
        logic [31:0] w;
        set_bins(0, {24'h777777, 24'h777777, 24'h777777, 24'h777777}, {3'd0, 3'd0, 3'd0, 3'd0}, 5'd0);
        base = q0.size();
        run_frame(0, n);
        total++; if (q0.size() - base !== 96) begin bad++; $display("FAIL zero_nbits got=%0d want=96", q0.size() - base); end
        for (int k = 0; k < 4; k++) begin
            w = word_at(0, base + 24 * k, 24);
            total++; if (w[23:0] !== 24'h000000) begin bad++; $display("FAIL zero_led%0d got=%06h want=000000", k, w[23:0]); end
        end
        $display("all-zero ws2801 frame: %0d bits", q0.size() - base);
    endtask

    task automatic test_apa102;
        logic [31:0] exp [4] = '{32'hE3112233, 32'hE3445566, 32'hE3445566, 32'hE3445566};
        int base, n, g;
        logic [31:0] w;
        set_bins(1, {24'h000000, 24'h000000, 24'h000000, 24'h0A0B0C}, {3'd0, 3'd0, 3'd0, 3'd4}, 5'h1F);
        base = q1.size(); g = glitch1;
        run_frame(1, n);
        total++; if (n !== 2 + 192 * FDIV + LCYC) begin bad++; $display("FAIL apa_cycles got=%0d want=%0d", n, 2 + 192 * FDIV + LCYC); end
        total++; if (q1.size() - base !== 192) begin bad++; $display("FAIL apa_nbits got=%0d want=192", q1.size() - base); end
        w = word_at(1, base, 32);
        total++; if (w !== 32'h0) begin bad++; $display("FAIL apa_start got=%08h want=00000000", w); end
        for (int k = 0; k < 4; k++) begin
            w = word_at(1, base + 32 + 32 * k, 32);
            total++; if (w !== 32'hFF0A0B0C) begin bad++; $display("FAIL apa_led%0d got=%08h want=FF0A0B0C", k, w); end
        end
        w = word_at(1, base + 160, 32);
        total++; if (w !== 32'hFFFFFFFF) begin bad++; $display("FAIL apa_end got=%08h want=FFFFFFFF", w); end
        total++; if (glitch1 - g !== 0) begin bad++; $display("FAIL apa_dout_high got=%0d changes want=0", glitch1 - g); end
        $display("apa102 frame 1: %0d bits in %0d clks", q1.size() - base, n);

        set_bins(1, {24'h000000, 24'h445566, 24'h999999, 24'h112233}, {3'd0, 3'd2, 3'd0, 3'd1}, 5'h03);
        base = q1.size();
        run_frame(1, n);
        for (int k = 0; k < 4; k++) begin
            w = word_at(1, base + 32 + 32 * k, 32);
            total++; if (w !== exp[k]) begin bad++; $display("FAIL apa2_led%0d got=%08h want=%08h", k, w, exp[k]); end
        end
        $display("apa102 frame 2: %0d bits", q1.size() - base);
    endtask

    task automatic test_back_to_back;
        logic [23:0] exp [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
        int base, sz, k;
        logic [31:0] w;
        set_bins(0, {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000}, {3'd1, 3'd1, 3'd1, 3'd1}, 5'd0);
        base = q0.size();
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (100) @(negedge clk);
        set_bins(0, {24'h0F0F0F, 24'h0F0F0F, 24'h0F0F0F, 24'h0F0F0F}, {3'd0, 3'd0, 3'd0, 3'd4}, 5'd0);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        total++; if (if0.done !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b want=0", if0.done); end
        k = 0;
        while (if0.done !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
        total++; if (if0.done !== 1'b1) begin bad++; $display("FAIL b2b_timeout got=%b want=1", if0.done); end
        for (int j = 0; j < 4; j++) begin
            w = word_at(0, base + 24 * j, 24);
            total++; if (w[23:0] !== exp[j]) begin bad++; $display("FAIL b2b_led%0d got=%06h want=%06h", j, w[23:0], exp[j]); end
        end
        sz = q0.size();
        repeat (30) @(negedge clk);
        total++; if (q0.size() - base !== 96) begin bad++; $display("FAIL b2b_no_queue got=%0d bits want=96", q0.size() - base); end
        total++; if (if0.done !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b want=1", if0.done); end
        $display("mid-frame start ignored: %0d bits, %0d after idle", q0.size() - base, q0.size() - sz);
    endtask

    task automatic test_reset_mid;
        int base, sz, k, n;
        logic [31:0] w;
        set_bins(0, {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000}, {3'd1, 3'd1, 3'd1, 3'd1}, 5'd0);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (150) @(negedge clk);
        k = 0;
        while (if0.clkOut !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        total++; if (if0.clkOut !== 1'b1) begin bad++; $display("FAIL rmid_shifting got=%b want=1", if0.clkOut); end
        #2 rst = 1'b0;
        #1;
        total++; if (if0.clkOut !== 1'b0) begin bad++; $display("FAIL rmid_clk got=%b want=0", if0.clkOut); end
        total++; if (if0.done !== 1'b0)   begin bad++; $display("FAIL rmid_done got=%b want=0", if0.done); end
        total++; if (if0.dOut !== 1'b0)   begin bad++; $display("FAIL rmid_dout got=%b want=0", if0.dOut); end
        sz = q0.size();
        repeat (3) @(negedge clk);
        total++; if (q0.size() !== sz) begin bad++; $display("FAIL rmid_quiet got=%0d edges want=0", q0.size() - sz); end
        rst = 1'b1;
        repeat (LCYC - 1) @(negedge clk);
        total++; if (if0.done !== 1'b0) begin bad++; $display("FAIL rmid_early got=%b want=0", if0.done); end
        @(negedge clk);
        total++; if (if0.done !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", if0.done); end
        base = q0.size();
        run_frame(0, n);
        total++; if (q0.size() - base !== 96) begin bad++; $display("FAIL rmid_again_nbits got=%0d want=96", q0.size() - base); end
        w = word_at(0, base, 24);
        total++; if (w[23:0] !== 24'hFF0000) begin bad++; $display("FAIL rmid_again_led0 got=%06h want=FF0000", w[23:0]); end
        $display("reset mid-shift: recovered frame of %0d bits", q0.size() - base);
    endtask

    initial begin
        if0.rgb = '0; if0.LEDCounts = '0; if0.brightness = '0; if0.start = 1'b0;
        if1.rgb = '0; if1.LEDCounts = '0; if1.brightness = '0; if1.start = 1'b0;
        rst = 1'b0;
        test_reset;
        test_basic;
        test_skip_zero;
        test_overflow;
        test_all_zero;
        test_apa102;
        test_back_to_back;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
